rv_muldiv: RTL and testbench

Iterative multiply/divide unit implementing the RV32M/RV64M operation set, parametrised in data width. Sits in the execute stage beside the single-cycle ALU. The pipeline stalls on `o_ready` low while a multi-cycle operation is in flight. One shared XLEN+1-bit adder/subtractor is reused every cycle: shift-add for multiply, restoring division for divide/remainder.

---
 rtl/rv_muldiv_pkg.sv | 25 ++
 rtl/rv_muldiv.sv | 188 ++++++++++++++++++
 tb/tb_rv_muldiv.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_muldiv_pkg.sv
// Shared types for the iterative RV32M/RV64M multiply/divide unit.
package rv_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  function automatic int cnt_width(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

endpackage

// File: rtl/rv_muldiv.sv
// Iterative multiply/divide: shift-add multiply and restoring divide
// sharing one XLEN+1-bit adder/subtractor.
module rv_muldiv
  import rv_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_valid,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_src_a,
  input  logic [XLEN-1:0] i_src_b,
  input  logic            i_flush,
  output logic            o_ready,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero
);

  localparam int CW = cnt_width(XLEN);
  localparam logic [XLEN-1:0] MINV =
    {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   state_q, state_d;
  muldiv_op_t      op_q, op_d;
  logic            neg_q, neg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] res_q, res_d;

  muldiv_op_t      in_op;
  logic            in_mul;
  logic            sgn_a, sgn_b;
  logic            a_neg, b_neg;
  logic            div0, ovf;
  logic            in_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] spec_res;

  assign in_op  = muldiv_op_t'(i_op);
  assign in_mul = ~i_op[2];

  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    unique case (in_op)
      OP_MULH, OP_DIV, OP_REM: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
      end
      OP_MULHSU: sgn_a = 1'b1;
      default: ;
    endcase
  end

  assign a_neg = sgn_a & i_src_a[XLEN-1];
  assign b_neg = sgn_b & i_src_b[XLEN-1];
  assign a_mag = a_neg ? -i_src_a : i_src_a;
  assign b_mag = b_neg ? -i_src_b : i_src_b;

  // Remainder takes the dividend's sign; everything else a^b.
  assign in_neg = (~in_mul & i_op[1]) ? a_neg
                                      : (a_neg ^ b_neg);

  assign div0 = i_op[2] & (i_src_b == '0);
  assign ovf  = i_op[2] & sgn_b
              & (i_src_a == MINV) & (i_src_b == '1);

  always_comb begin
    if (div0) spec_res = i_op[1] ? i_src_a : '1;
    else      spec_res = i_op[1] ? '0 : i_src_a;
  end

  logic            sub;
  logic [XLEN:0]   add_a, add_b, sum;
  logic [XLEN:0]   macc;
  logic [XLEN-1:0] hi_step, lo_step;

  // Divide feeds the left-shifted remainder; multiply the upper half.
  always_comb begin
    sub   = op_q[2];
    add_a = sub ? {hi_q, lo_q[XLEN-1]} : {1'b0, hi_q};
    add_b = {1'b0, dvs_q} ^ {(XLEN+1){sub}};
    sum   = add_a + add_b + {{XLEN{1'b0}}, sub};
  end

  always_comb begin
    macc = lo_q[0] ? sum : add_a;
    if (op_q[2]) begin
      hi_step = sum[XLEN] ? add_a[XLEN-1:0]
                          : sum[XLEN-1:0];
      lo_step = {lo_q[XLEN-2:0], ~sum[XLEN]};
    end else begin
      hi_step = macc[XLEN:1];
      lo_step = {macc[0], lo_q[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   dres, dres_s, fin;

  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = neg_q ? -prod : prod;
    dres   = op_q[1] ? hi_q : lo_q;
    dres_s = neg_q ? -dres : dres;
    if (op_q[2])
      fin = dres_s;
    else if (op_q == OP_MUL)
      fin = prod_s[XLEN-1:0];
    else
      fin = prod_s[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid && !i_flush) begin
          op_d  = in_op;
          neg_d = in_neg;
          cnt_d = '0;
          hi_d  = '0;
          lo_d  = in_mul ? b_mag : a_mag;
          dvs_d = in_mul ? a_mag : b_mag;
          if (div0 || ovf) begin
            res_d   = spec_res;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (i_flush) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(XLEN)) begin
          res_d   = fin;
          state_d = DONE;
        end else begin
          hi_d  = hi_step;
          lo_d  = lo_step;
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
    end
  end

  assign o_ready  = (state_q == IDLE);
  assign o_valid  = (state_q == DONE);
  assign o_result = res_q;
  assign o_zero   = (res_q == '0);

endmodule

// File: tb/tb_rv_muldiv.sv
// Bench for rv_muldiv: XLEN=32 and XLEN=64 instances checked
// against a wide-integer arithmetic model.
module tb_rv_muldiv;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  logic [1:0]       v = '0;
  logic [1:0][2:0]  op = '0;
  logic [1:0][63:0] a = '0;
  logic [1:0][63:0] b = '0;
  logic [1:0]       rdy, vo, zo;
  logic [31:0]      res32;
  logic [63:0]      res64;

  int n_chk = 0;
  int n_fail = 0;

  logic [1:0]  pend = '0;
  logic [63:0] expv [2];
  int          n_acc [2];
  int          n_done [2];

  always #5 clk = ~clk;

  rv_muldiv #(.XLEN(32)) u32 (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_valid(v[0]), .i_op(op[0]),
    .i_src_a(a[0][31:0]), .i_src_b(b[0][31:0]),
    .i_flush(flush),
    .o_ready(rdy[0]), .o_valid(vo[0]),
    .o_result(res32), .o_zero(zo[0])
  );

  rv_muldiv #(.XLEN(64)) u64 (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_valid(v[1]), .i_op(op[1]),
    .i_src_a(a[1]), .i_src_b(b[1]),
    .i_flush(flush),
    .o_ready(rdy[1]), .o_valid(vo[1]),
    .o_result(res64), .o_zero(zo[1])
  );

  function automatic logic [63:0] model(
    input int xl, input logic [2:0] f,
    input logic [63:0] x, input logic [63:0] y);
    logic [63:0] m;
    logic signed [129:0] xu, yu, xs, ys, p;
    m  = (xl == 64) ? '1 : ((64'd1 << xl) - 64'd1);
    xu = {66'd0, x & m};
    yu = {66'd0, y & m};
    xs = xu;
    ys = yu;
    if (x[xl-1]) xs = xu - (130'sd1 <<< xl);
    if (y[xl-1]) ys = yu - (130'sd1 <<< xl);
    p = '0;
    case (f)
      3'd0: p = xu * yu;
      3'd1: p = (xs * ys) >>> xl;
      3'd2: p = (xs * yu) >>> xl;
      3'd3: p = (xu * yu) >>> xl;
      3'd4: if (yu == 0) p = {66'd0, m};
            else p = xs / ys;
      3'd5: if (yu == 0) p = {66'd0, m};
            else p = xu / yu;
      3'd6: if (yu == 0) p = xs;
            else p = xs % ys;
      default: if (yu == 0) p = xu;
               else p = xu % yu;
    endcase
    return p[63:0] & m;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: one operation in flight per unit.
  initial begin
    logic [63:0] rv;
    expv[0] = '0; expv[1] = '0;
    n_acc[0] = 0; n_acc[1] = 0;
    n_done[0] = 0; n_done[1] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = '0;
      end else begin
        for (int d = 0; d < 2; d++) begin
          rv = (d == 1) ? res64 : {32'd0, res32};
          if (vo[d]) begin
            if (!pend[d]) begin
              n_chk++;
              n_fail++;
              $display("FAIL spurious_valid_u%0d: got 1 expected 0", d);
            end else begin
              chk($sformatf("model_result_u%0d", d), rv, expv[d]);
              chk($sformatf("model_zero_u%0d", d),
                  {63'd0, zo[d]}, {63'd0, expv[d] == 0});
              pend[d] = 1'b0;
              n_done[d]++;
            end
          end
          if (v[d] && rdy[d] && !flush) begin
            pend[d] = 1'b1;
            expv[d] = model((d == 1) ? 64 : 32, op[d], a[d], b[d]);
            n_acc[d]++;
          end
          if (flush && !rdy[d] && !vo[d]) pend[d] = 1'b0;
        end
      end
    end
  end

  task automatic issue(input int d, input logic [2:0] f,
                       input logic [63:0] x, input logic [63:0] y);
    int t;
    t = 0;
    v[d] = 1'b1; op[d] = f; a[d] = x; b[d] = y;
    forever begin
      @(negedge clk);
      if (rdy[d]) break;
      t++;
      if (t > 300) begin
        n_chk++;
        n_fail++;
        $display("FAIL accept_timeout_u%0d: got no accept expected accept", d);
        break;
      end
    end
    @(posedge clk);
    #1;
    v[d] = 1'b0;
  endtask

  task automatic run32(input string nm, input logic [2:0] f,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] e, input int lat);
    int n;
    n = 0;
    issue(0, f, {32'd0, x}, {32'd0, y});
    forever begin
      @(negedge clk);
      if (vo[0]) break;
      chk({nm, "_ready_low"}, {63'd0, rdy[0]}, 64'd0);
      @(posedge clk);
      n++;
      if (n > 100) begin
        chk({nm, "_valid_timeout"}, 64'd0, 64'd1);
        break;
      end
    end
    chk({nm, "_result"}, {32'd0, res32}, {32'd0, e});
    chk({nm, "_latency"}, 64'(n), 64'(lat));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int left [2];
    int gap [2];
    int cyc;
    int base_acc [2];
    int base_done [2];
    logic [1:0] took;
    logic [63:0] m, x, y;
    int xl, r;

    #3;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready_u%0d", d), {63'd0, rdy[d]}, 64'd1);
      chk($sformatf("rst_valid_u%0d", d), {63'd0, vo[d]}, 64'd0);
      chk($sformatf("rst_zero_u%0d", d), {63'd0, zo[d]}, 64'd1);
    end
    chk("rst_result_u0", {32'd0, res32}, 64'd0);
    chk("rst_result_u1", res64, 64'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run32("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run32("mulh",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run32("mulhu",  3'd3, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run32("mulhsu", 3'd2, 32'h80000000, 32'h80000000, 32'hC0000000, 33);
    run32("div",    3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run32("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run32("divu",   3'd5, 32'd100,      32'd7,        32'd14,       33);
    run32("remu",   3'd7, 32'd100,      32'd7,        32'd2,        33);
    run32("divu0",  3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 0);
    run32("rem0",   3'd6, 32'd5,        32'd0,        32'd5,        0);
    run32("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
    run32("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0);
    chk("removf_zero", {63'd0, zo[0]}, 64'd1);
    run32("divu_b", 3'd5, 32'd100,      32'd7,        32'd14,       33);

    issue(0, 3'd4, 64'd1000, 64'd3);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_ready", {63'd0, rdy[0]}, 64'd1);
    chk("flush_valid", {63'd0, vo[0]}, 64'd0);
    chk("flush_hold", {32'd0, res32}, 64'd14);
    repeat (40) @(posedge clk);
    #1;
    v[0] = 1'b1; op[0] = 3'd5; a[0] = 64'd50; b[0] = 64'd5;
    flush = 1'b1;
    @(posedge clk);
    #1 v[0] = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_ready", {63'd0, rdy[0]}, 64'd1);
    chk("flush_idle_hold", {32'd0, res32}, 64'd14);
    @(posedge clk);
    #1;

    issue(0, 3'd0, 64'd3, 64'd5);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", {63'd0, rdy[0]}, 64'd1);
    chk("midrst_valid", {63'd0, vo[0]}, 64'd0);
    chk("midrst_result", {32'd0, res32}, 64'd0);
    chk("midrst_zero", {63'd0, zo[0]}, 64'd1);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int d = 0; d < 2; d++) begin
      left[d] = 40;
      gap[d] = 0;
      base_acc[d] = n_acc[d];
      base_done[d] = n_done[d];
    end
    cyc = 0;
    while ((left[0] > 0 || left[1] > 0 || v != 0 || pend != 0)
           && cyc < 20000) begin
      @(negedge clk);
      took = v & rdy;
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (took[d]) begin
          v[d] = 1'b0;
          left[d]--;
          gap[d] = $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0;
        end
        if (!v[d] && left[d] > 0) begin
          if (gap[d] > 0) begin
            gap[d]--;
          end else begin
            xl = (d == 1) ? 64 : 32;
            m  = (xl == 64) ? '1 : 64'hFFFF_FFFF;
            x  = {$urandom, $urandom} & m;
            y  = {$urandom, $urandom} & m;
            r  = $urandom_range(0, 7);
            if (r == 0) y = '0;
            if (r == 1) begin
              x = 64'd1 << (xl - 1);
              y = m;
            end
            if (r == 2) begin
              x = 64'($urandom_range(0, 300));
              y = 64'($urandom_range(1, 20));
              if ($urandom_range(0, 1) == 1) x = (~x + 64'd1) & m;
              if ($urandom_range(0, 1) == 1) y = (~y + 64'd1) & m;
            end
            v[d]  = 1'b1;
            op[d] = 3'($urandom_range(0, 7));
            a[d]  = x;
            b[d]  = y;
          end
        end
      end
    end
    if (cyc >= 20000)
      chk("random_drain", 64'(cyc), 64'd0);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rand_accepts_u%0d", d),
          64'(n_acc[d] - base_acc[d]), 64'd40);
      chk($sformatf("rand_results_u%0d", d),
          64'(n_done[d] - base_done[d]), 64'd40);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
